// File: rtl/cpu_regs_pkg.sv
// Shared encodings for the banked register unit: register index offsets,
// stack-pointer operations and segment selectors.
package cpu_regs_pkg;

   // Special register indices are offsets above NUM_GPR; IDX_NONE is absolute.
   localparam int IDX_NONE = 0;
   localparam int IDX_SP   = 1;
   localparam int IDX_SB   = 2;
   localparam int IDX_CS   = 3;
   localparam int IDX_DS   = 4;
   localparam int IDX_SS   = 5;
   localparam int IDX_ES   = 6;
   localparam int NUM_SEG  = 4;

   typedef enum logic [1:0] {
      SP_NONE = 2'b00,
      SP_PUSH = 2'b01,
      SP_POP  = 2'b10,
      SP_RSVD = 2'b11
   } sp_op_e;

   typedef enum logic [2:0] {
      SEG_NONE = 3'd0,
      SEG_CS   = 3'd1,
      SEG_DS   = 3'd2,
      SEG_SS   = 3'd3,
      SEG_ES   = 3'd4
   } seg_sel_e;

endpackage

// File: rtl/stack_pointer_ctrl.sv
// Stack pointer and stack base with guarded push/pop and sticky error flags.
module stack_pointer_ctrl
   import cpu_regs_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] STACK_TOP = '1
) (
   input  logic             clk,
   input  logic             r,
   input  logic [1:0]       sp_op,
   input  logic             sp_wr,
   input  logic             sb_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] sp,
   output logic [WIDTH-1:0] sb,
   output logic             ovf,
   output logic             unf
);

   always_ff @(posedge clk) begin
      if (r) begin
         sp  <= STACK_TOP;
         sb  <= STACK_TOP;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (sp_wr) begin
         // An explicit SP load wins over push/pop and restarts error tracking.
         sp  <= wdata;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (sb_wr) begin
            sb  <= wdata;
            unf <= 1'b0;
         end
         // Guards compare against pre-edge SP/SB; a same-cycle underflow beats the SB clear.
         case (sp_op_e'(sp_op))
            SP_PUSH: begin
               if (sp == '0) ovf <= 1'b1;
               else          sp  <= sp - 1'b1;
            end
            SP_POP: begin
               if (sp == sb) unf <= 1'b1;
               else          sp  <= sp + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/banked_register_unit.sv
// Banked GPR file with SP/SB/segment registers, one bus read port,
// two ALU read ports and a bank swap for fast context switching.
module banked_register_unit
   import cpu_regs_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               NUM_GPR   = 5,
   parameter int               NUM_BANKS = 2,
   parameter logic [WIDTH-1:0] STACK_TOP = '1,
   parameter int               SEL_W     = $clog2(NUM_GPR + 7),
   parameter int               BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic              clk,
   input  logic              r,
   input  logic [WIDTH-1:0]  bus_in,
   output logic [WIDTH-1:0]  bus_out,
   output logic              bus_drive,
   input  logic [SEL_W-1:0]  wsel,
   input  logic [SEL_W-1:0]  rsel,
   input  logic [SEL_W-1:0]  ra_sel,
   input  logic [SEL_W-1:0]  rb_sel,
   output logic [WIDTH-1:0]  ra_data,
   output logic [WIDTH-1:0]  rb_data,
   input  logic [1:0]        sp_op,
   output logic [WIDTH-1:0]  sp_out,
   input  logic [2:0]        seg_sel,
   output logic [WIDTH-1:0]  seg_out,
   input  logic              bank_swap,
   output logic [BANK_W-1:0] bank,
   output logic              stack_ovf,
   output logic              stack_unf
);

   localparam int NUM_VIEW = NUM_GPR + IDX_ES + 1;
   localparam int GPR_IW   = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

   logic [WIDTH-1:0]  gpr [NUM_BANKS][NUM_GPR];
   logic [WIDTH-1:0]  seg [NUM_SEG];
   logic [WIDTH-1:0]  sp;
   logic [WIDTH-1:0]  sb;
   logic [WIDTH-1:0]  view [NUM_VIEW];
   logic [31:0]       wsel_x;
   logic [GPR_IW-1:0] gpr_idx;
   logic [1:0]        seg_idx;
   logic              gpr_wr;
   logic              seg_wr;
   logic              sp_wr;
   logic              sb_wr;

   function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
      return (32'(sel) != IDX_NONE) && (32'(sel) < NUM_VIEW);
   endfunction

   assign wsel_x  = 32'(wsel);
   assign gpr_wr  = (wsel_x >= 1) && (wsel_x <= NUM_GPR);
   assign seg_wr  = (wsel_x >= NUM_GPR + IDX_CS) && (wsel_x <= NUM_GPR + IDX_ES);
   assign sp_wr   = (wsel_x == NUM_GPR + IDX_SP);
   assign sb_wr   = (wsel_x == NUM_GPR + IDX_SB);
   assign gpr_idx = GPR_IW'(wsel_x - 1);
   assign seg_idx = 2'(wsel_x - (NUM_GPR + IDX_CS));

   stack_pointer_ctrl #(
      .WIDTH     (WIDTH),
      .STACK_TOP (STACK_TOP)
   ) u_sp (
      .clk   (clk),
      .r     (r),
      .sp_op (sp_op),
      .sp_wr (sp_wr),
      .sb_wr (sb_wr),
      .wdata (bus_in),
      .sp    (sp),
      .sb    (sb),
      .ovf   (stack_ovf),
      .unf   (stack_unf)
   );

   // GPR writes target the bank that is active before any same-cycle swap.
   always_ff @(posedge clk) begin
      if (r) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int g = 0; g < NUM_GPR; g++)
               gpr[b][g] <= '0;
         for (int s = 0; s < NUM_SEG; s++)
            seg[s] <= '0;
         bank <= '0;
      end else begin
         if (gpr_wr) gpr[bank][gpr_idx] <= bus_in;
         if (seg_wr) seg[seg_idx] <= bus_in;
         if (bank_swap && (NUM_BANKS > 1)) begin
            if (bank == BANK_W'(NUM_BANKS - 1)) bank <= '0;
            else                                 bank <= bank + 1'b1;
         end
      end
   end

   // Flat index-ordered view of the active bank plus special registers.
   always_comb begin
      for (int i = 0; i < NUM_VIEW; i++)
         view[i] = '0;
      for (int g = 0; g < NUM_GPR; g++)
         view[g + 1] = gpr[bank][g];
      view[NUM_GPR + IDX_SP] = sp;
      view[NUM_GPR + IDX_SB] = sb;
      for (int s = 0; s < NUM_SEG; s++)
         view[NUM_GPR + IDX_CS + s] = seg[s];
   end

   always_comb begin
      bus_drive = sel_valid(rsel);
      bus_out   = sel_valid(rsel)   ? view[rsel]   : '0;
      ra_data   = sel_valid(ra_sel) ? view[ra_sel] : '0;
      rb_data   = sel_valid(rb_sel) ? view[rb_sel] : '0;
      sp_out    = sp;
   end

   always_comb begin
      seg_out = '0;
      case (seg_sel_e'(seg_sel))
         SEG_CS:  seg_out = seg[0];
         SEG_DS:  seg_out = seg[1];
         SEG_SS:  seg_out = seg[2];
         SEG_ES:  seg_out = seg[3];
         default: seg_out = '0;
      endcase
   end

endmodule
